// File: rtl/mod_exp_ctrl_if.sv
// Montgomery multiplier handshake bundle between the exponentiation sequencer and the multiplier.
interface mod_exp_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 8
);
    logic             md_start;
    logic [LEN_W-1:0] mm_len;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_mod;
    logic             md_end;
    logic [WIDTH-1:0] mm_out;

    modport master (
        output md_start, mm_len, mm_a, mm_b, mm_mod,
        input  md_end, mm_out
    );

    modport slave (
        input  md_start, mm_len, mm_a, mm_b, mm_mod,
        output md_end, mm_out
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Every product runs WAIT_LOW -> ISSUE -> WAIT_END so a stretched md_end is consumed once.
module mod_exp_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned EXP_BITS = 32,
    parameter int unsigned LEN_W    = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic [5:0]          exp_len,
    input  logic [WIDTH-1:0]    base,
    input  logic [EXP_BITS-1:0] exponent,
    input  logic [WIDTH-1:0]    modulus,
    input  logic [WIDTH-1:0]    r2_mod,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    mod_exp_ctrl_if.master      mm
);
    localparam int unsigned IDX_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV_M, S_CONV_X, S_SQR, S_MUL, S_FINAL, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_WAIT_LOW, P_ISSUE, P_WAIT_END
    } phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    x_q, x_d, m_bar_q, m_bar_d;
    logic [WIDTH-1:0]    base_q, base_d, r2_q, r2_d, mod_q, mod_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic [5:0]          exp_len_q, exp_len_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                md_start_q, md_start_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic                md_end_q;
    logic                md_rise;

    assign md_rise = mm.md_end & ~md_end_q;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            phase_q    <= P_WAIT_LOW;
            idx_q      <= '0;
            x_q        <= '0;
            m_bar_q    <= '0;
            base_q     <= '0;
            r2_q       <= '0;
            mod_q      <= '0;
            exp_q      <= '0;
            exp_len_q  <= '0;
            len_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            md_start_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            md_end_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            m_bar_q    <= m_bar_d;
            base_q     <= base_d;
            r2_q       <= r2_d;
            mod_q      <= mod_d;
            exp_q      <= exp_d;
            exp_len_q  <= exp_len_d;
            len_q      <= len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            md_start_q <= md_start_d;
            a_q        <= a_d;
            b_q        <= b_d;
            md_end_q   <= mm.md_end;
        end
    end

    // Next-state, datapath capture and operand selection
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        x_d        = x_q;
        m_bar_d    = m_bar_q;
        base_d     = base_q;
        r2_d       = r2_q;
        mod_d      = mod_q;
        exp_d      = exp_q;
        exp_len_d  = exp_len_q;
        len_d      = len_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        md_start_d = 1'b0;
        a_d        = a_q;
        b_d        = b_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = len;
                    exp_len_d = exp_len;
                    exp_d     = exponent;
                    mod_d     = modulus;
                    r2_d      = r2_mod;
                    base_d    = base;
                    idx_d     = IDX_W'(exp_len - 6'd1);
                    busy_d    = 1'b1;
                    phase_d   = P_WAIT_LOW;
                    state_d   = S_CONV_M;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                case (phase_q)
                    P_WAIT_LOW: begin
                        if (!mm.md_end) begin
                            phase_d    = P_ISSUE;
                            md_start_d = 1'b1;
                            case (state_q)
                                S_CONV_M: begin a_d = base_q; b_d = r2_q;    end
                                S_CONV_X: begin a_d = ONE;    b_d = r2_q;    end
                                S_SQR:    begin a_d = x_q;    b_d = x_q;     end
                                S_MUL:    begin a_d = x_q;    b_d = m_bar_q; end
                                default:  begin a_d = x_q;    b_d = ONE;     end
                            endcase
                        end
                    end
                    P_ISSUE: phase_d = P_WAIT_END;
                    default: begin
                        if (md_rise) begin
                            phase_d = P_WAIT_LOW;
                            case (state_q)
                                S_CONV_M: begin
                                    m_bar_d = mm.mm_out;
                                    state_d = S_CONV_X;
                                end
                                S_CONV_X: begin
                                    x_d     = mm.mm_out;
                                    state_d = (exp_len_q == 6'd0) ? S_FINAL : S_SQR;
                                end
                                S_SQR: begin
                                    x_d = mm.mm_out;
                                    if (exp_q[idx_q]) begin
                                        state_d = S_MUL;
                                    end else if (idx_q == '0) begin
                                        state_d = S_FINAL;
                                    end else begin
                                        idx_d   = idx_q - IDX_W'(1);
                                        state_d = S_SQR;
                                    end
                                end
                                S_MUL: begin
                                    x_d = mm.mm_out;
                                    if (idx_q == '0) begin
                                        state_d = S_FINAL;
                                    end else begin
                                        idx_d   = idx_q - IDX_W'(1);
                                        state_d = S_SQR;
                                    end
                                end
                                default: begin
                                    result_d = mm.mm_out;
                                    done_d   = 1'b1;
                                    busy_d   = 1'b0;
                                    state_d  = S_DONE;
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign mm.md_start = md_start_q;
    assign mm.mm_len   = len_q;
    assign mm.mm_a     = a_q;
    assign mm.mm_b     = b_q;
    assign mm.mm_mod   = mod_q;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier plus a result scoreboard.
module tb_mod_exp_ctrl;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned EXP_BITS = 32;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned LAT      = 5;
    localparam int unsigned TMO      = 3000;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                start = 1'b0;
    logic [LEN_W-1:0]    len = '0;
    logic [5:0]          exp_len = '0;
    logic [WIDTH-1:0]    base = '0;
    logic [EXP_BITS-1:0] exponent = '0;
    logic [WIDTH-1:0]    modulus = '0;
    logic [WIDTH-1:0]    r2_mod = '0;
    logic                busy, done;
    logic [WIDTH-1:0]    result;

    mod_exp_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) mif ();

    mod_exp_ctrl #(.WIDTH(WIDTH), .EXP_BITS(EXP_BITS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .exp_len(exp_len),
        .base(base), .exponent(exponent), .modulus(modulus), .r2_mod(r2_mod),
        .busy(busy), .done(done), .result(result), .mm(mif.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] sb[$];

    // Bit-serial Montgomery product a*b*2^-k mod n
    function automatic logic [WIDTH-1:0] mont(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] n, input logic [LEN_W-1:0] k);
        logic [WIDTH+1:0] t;
        t = '0;
        for (int i = 0; i < int'(k) && i < int'(WIDTH); i++) begin
            if (a[i]) t = t + (WIDTH+2)'(b);
            if (t[0]) t = t + (WIDTH+2)'(n);
            t = t >> 1;
        end
        if (t >= (WIDTH+2)'(n)) t = t - (WIDTH+2)'(n);
        return WIDTH'(t);
    endfunction

    // Plain modular exponentiation reference
    function automatic logic [WIDTH-1:0] ref_modexp(input logic [WIDTH-1:0] b, input logic [EXP_BITS-1:0] e,
                                                    input logic [5:0] el, input logic [WIDTH-1:0] n);
        logic [63:0] r;
        r = 64'd1 % 64'(n);
        for (int i = int'(el) - 1; i >= 0; i--) begin
            r = (r * r) % 64'(n);
            if (e[i]) r = (r * 64'(b)) % 64'(n);
        end
        return WIDTH'(r);
    endfunction

    logic             md_end_r;
    logic [WIDTH-1:0] mm_out_r, pend;
    int               cnt, hcnt;
    int               hold_len = 1;
    int               pulses = 0, viol = 0, dones = 0;

    assign mif.md_end = md_end_r;
    assign mif.mm_out = mm_out_r;

    // Multiplier model: LAT cycles after md_start, md_end high for hold_len cycles
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            md_end_r <= 1'b0;
            mm_out_r <= '0;
            cnt      <= 0;
            hcnt     <= 0;
        end else begin
            if (hcnt != 0) begin
                hcnt <= hcnt - 1;
                if (hcnt == 1) md_end_r <= 1'b0;
            end
            if (mif.md_start) begin
                pend <= mont(mif.mm_a, mif.mm_b, mif.mm_mod, mif.mm_len);
                cnt  <= LAT;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    md_end_r <= 1'b1;
                    mm_out_r <= pend;
                    hcnt     <= hold_len;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mif.md_start) pulses <= pulses + 1;
        if (mif.md_start && mif.md_end) viol <= viol + 1;
        if (done) dones <= dones + 1;
    end

    task automatic start_job(input logic [WIDTH-1:0] b, input logic [EXP_BITS-1:0] e, input logic [5:0] el);
        @(posedge clk); #1;
        base = b; exponent = e; exp_len = el;
        len = 8'd8; modulus = 187; r2_mod = 86;
        start = 1'b1;
        sb.push_back(ref_modexp(b, e, el, 187));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < int'(TMO); i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, mif.md_start} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctl: got %b required 000", {busy, done, mif.md_start});
        end
        n_chk++;
        if (result !== '0) begin
            n_fail++; $display("FAIL reset_result: got %0d required 0", result);
        end
        n_chk++;
        if ({mif.mm_a, mif.mm_b, mif.mm_mod, mif.mm_len} !== '0) begin
            n_fail++; $display("FAIL reset_mm: a=%0d b=%0d mod=%0d len=%0d required all 0",
                               mif.mm_a, mif.mm_b, mif.mm_mod, mif.mm_len);
        end
        @(negedge clk); rstn = 1'b1;
    endtask

    task automatic test_basic;
        int p0, d0;
        bit ok;
        logic [WIDTH-1:0] exp_r;
        p0 = pulses; d0 = dones;
        start_job(88, 7, 3);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
        wait_done(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done required done"); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b required 0", busy); end
        exp_r = sb.pop_front();
        n_chk++;
        if (result !== exp_r) begin n_fail++; $display("FAIL basic_result: got %0d required %0d", result, exp_r); end
        @(posedge clk); #1;
        n_chk++;
        if (done !== 1'b0 || dones - d0 != 1) begin
            n_fail++; $display("FAIL basic_done_pulse: got done=%b count=%0d required 0/1", done, dones - d0);
        end
        n_chk++;
        if (pulses - p0 != 9) begin n_fail++; $display("FAIL basic_pulses: got %0d required 9", pulses - p0); end
    endtask

    task automatic test_rsa;
        int p0;
        bit ok;
        logic [WIDTH-1:0] exp_r;
        p0 = pulses;
        start_job(11, 23, 5);
        wait_done(ok);
        exp_r = sb.pop_front();
        n_chk++;
        if (!ok || result !== exp_r || exp_r !== 32'd88) begin
            n_fail++; $display("FAIL rsa_result: got %0d (done=%b) required 88", result, ok);
        end
        @(posedge clk); #1;
        n_chk++;
        if (pulses - p0 != 12) begin n_fail++; $display("FAIL rsa_pulses: got %0d required 12", pulses - p0); end
    endtask

    task automatic test_explen0;
        int p0;
        bit ok;
        logic [WIDTH-1:0] exp_r;
        p0 = pulses;
        start_job(88, 7, 0);
        repeat (3) @(posedge clk);
        #1;
        base = 5; exponent = 32'hFF; exp_len = 6'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ok);
        exp_r = sb.pop_front();
        n_chk++;
        if (!ok || result !== exp_r || exp_r !== 32'd1) begin
            n_fail++; $display("FAIL explen0_result: got %0d (done=%b) required 1", result, ok);
        end
        repeat (20) @(posedge clk);
        #1;
        n_chk++;
        if (pulses - p0 != 3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL explen0_pulses: got %0d busy=%b required 3 busy=0", pulses - p0, busy);
        end
    endtask

    task automatic test_stretch;
        int p0, v0;
        bit ok;
        logic [WIDTH-1:0] exp_r;
        hold_len = 4;
        p0 = pulses; v0 = viol;
        start_job(88, 7, 3);
        wait_done(ok);
        exp_r = sb.pop_front();
        n_chk++;
        if (!ok || result !== exp_r) begin
            n_fail++; $display("FAIL stretch_result: got %0d (done=%b) required %0d", result, ok, exp_r);
        end
        repeat (6) @(posedge clk);
        #1;
        n_chk++;
        if (pulses - p0 != 9) begin n_fail++; $display("FAIL stretch_pulses: got %0d required 9", pulses - p0); end
        n_chk++;
        if (viol != v0) begin n_fail++; $display("FAIL stretch_overlap: got %0d required 0", viol - v0); end
        hold_len = 1;
    endtask

    task automatic test_reset_mid;
        int p0, d0;
        bit ok, reached;
        logic [WIDTH-1:0] exp_r;
        p0 = pulses; d0 = dones; reached = 1'b0;
        start_job(88, 7, 3);
        for (int i = 0; i < int'(TMO); i++) begin
            if (pulses - p0 >= 3) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_chk++;
        if (!reached) begin n_fail++; $display("FAIL rstmid_reach_sqr: got %0d pulses required 3", pulses - p0); end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        void'(sb.pop_front());
        n_chk++;
        if ({busy, done, mif.md_start} !== 3'b000 || result !== '0 || {mif.mm_a, mif.mm_b, mif.mm_mod} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got busy=%b done=%b md_start=%b result=%0d required all 0",
                               busy, done, mif.md_start, result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        n_chk++;
        if (dones != d0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d required 0", dones - d0); end
        start_job(88, 7, 3);
        wait_done(ok);
        exp_r = sb.pop_front();
        n_chk++;
        if (!ok || result !== exp_r) begin
            n_fail++; $display("FAIL rstmid_fresh: got %0d (done=%b) required %0d", result, ok, exp_r);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, held;
        logic [WIDTH-1:0] exp_a, exp_b;
        start_job(88, 7, 3);
        wait_done(ok);
        exp_a = sb.pop_front();
        n_chk++;
        if (!ok || result !== exp_a) begin
            n_fail++; $display("FAIL b2b_first: got %0d (done=%b) required %0d", result, ok, exp_a);
        end
        start_job(11, 23, 5);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b required 1", busy); end
        ok = 1'b0; held = 1'b1;
        for (int i = 0; i < int'(TMO); i++) begin
            if (done) begin ok = 1'b1; break; end
            if (result !== exp_a) held = 1'b0;
            @(posedge clk); #1;
        end
        n_chk++;
        if (!held) begin n_fail++; $display("FAIL b2b_hold: got result change required %0d", exp_a); end
        exp_b = sb.pop_front();
        n_chk++;
        if (!ok || result !== exp_b) begin
            n_fail++; $display("FAIL b2b_second: got %0d (done=%b) required %0d", result, ok, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rsa();
        test_explen0();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Initiator-side sequencer for the Montgomery multiplier handshake (md_start / md_end / mm_out).
- Computes result = base^exponent mod modulus by left-to-right square-and-multiply.
- Issues one Montgomery product per request to an external multiplier and consumes each result.
- Sits between the RSA top-level (encrypt/decrypt command) and the multiplier instance; it owns all operand muxing and sequencing.

Parameters:
- WIDTH, 32, operand/modulus width; matches the multiplier data ports.
- EXP_BITS, 32, maximum exponent width.
- LEN_W, 8, width of the len field driven to the multiplier.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- len  in  LEN_W  Montgomery bit length k (R = 2^k); forwarded unchanged to multiplier
- exp_len  in  6  number of significant exponent bits (0..EXP_BITS); latched at start
- base  in  WIDTH  message, must be < modulus
- exponent  in  EXP_BITS  exponent; latched at start
- modulus  in  WIDTH  odd modulus N; latched at start
- r2_mod  in  WIDTH  R^2 mod N, precomputed by software; latched at start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse; result valid from this cycle until next accepted start
- result  out  WIDTH  base^exponent mod N
- md_start  out  1  one-cycle request pulse to multiplier
- mm_len  out  LEN_W  = latched len
- mm_a  out  WIDTH  multiplier num_1
- mm_b  out  WIDTH  multiplier num_2
- mm_mod  out  WIDTH  = latched modulus
- md_end  in  1  multiplier completion flag; may stay high for more than one cycle
- mm_out  in  WIDTH  multiplier result; valid while md_end is high

Behaviour:
- Reset (async, rstn=0): all outputs are 0; state = IDLE; internal registers x, m_bar, and bit index are 0. Reset mid-operation abandons the sequence with no done pulse. The multiplier is reset by the same rstn.
- Latching at start: start in IDLE latches len, exp_len, exponent, modulus, r2_mod, and base. start outside IDLE is ignored.
- Top states: IDLE -> CONV_M -> CONV_X -> SQR -> (MUL if bit set) -> ... -> FINAL -> DONE -> IDLE.
  - CONV_M: m_bar = MM(base, r2_mod).
  - CONV_X: x = MM(1, r2_mod), i.e. R mod N.
  - SQR: x = MM(x, x). Then if exponent[idx] = 1 go to MUL, else decrement idx.
  - MUL: x = MM(x, m_bar).
  - idx starts at exp_len-1. After the last bit (idx = 0) processed, go to FINAL.
  - FINAL: result = MM(x, 1).
  - DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- exp_len = 0: skip from CONV_X directly to FINAL; result = 1 mod N (1, or 0 when N = 1).
- Per-product sub-phase handshake, applied identically in every op state:
  - ISSUE: drive mm_a/mm_b and pulse md_start for exactly 1 cycle.
  - WAIT_END: wait for a rising edge of md_end (md_end = 1 while the registered previous value = 0); capture mm_out into the destination register in that cycle.
  - WAIT_LOW: wait until md_end = 0 before the next ISSUE, so a stretched md_end is never double-counted.
- mm_a/mm_b hold stable from ISSUE through the capture cycle.
- md_start never asserts while md_end = 1.
- Latency: 2 + exp_len + popcount(exponent[exp_len-1:0]) + 1 products. Each product costs 1 (ISSUE) + multiplier latency + 1 (WAIT_LOW minimum) cycles, plus 1 DONE cycle.
- No timeout: a stalled md_end holds the block in WAIT_END indefinitely, with busy = 1.
- Arithmetic: no modular arithmetic is done locally; all reduction happens in the multiplier. Constant operand 1 is zero-extended to WIDTH.

Test Plan:
1. Bench multiplier model with 5-cycle latency; len=8, N=187, r2_mod=86, base=88, exponent=7, exp_len=3 -> exactly 9 md_start pulses, result=11, one done pulse, busy low afterwards.
2. Same model; base=11, exponent=23, exp_len=5 -> 5+2+4+1 = 12 pulses, result=88 (RSA round trip).
3. exp_len=0 with N=187 -> 3 md_start pulses, result=1; start asserted while busy is ignored, with no change to pulse count or result.
4. Model holds md_end high 4 cycles per completion -> still 9 captures for scenario 1 data, result=11, no md_start while md_end=1.
5. rstn pulsed low during SQR WAIT_END -> all outputs 0 immediately, no done; a fresh start then gives result=11 for scenario 1 data.
6. Back-to-back jobs: start asserted the cycle after done -> accepted; second job's result correct, and result holds the first value until second done.
